// File: rtl/bus_timer.sv
// Memory-mapped prescaled down-counter timer with one-shot/auto-reload modes, sticky DONE and irq pulse.
// Writes take effect at the sampling edge; rdata is registered (1-cycle read latency) and zero when unselected.
module bus_timer #(
  parameter logic [3:0] BASE     = 4'h4,
  parameter int         PRESCALE = 50000
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic [15:0] rdata,
  output logic        irq
);

  localparam logic [15:0] P_MAX = 16'(PRESCALE - 1);

  typedef enum logic {
    S_IDLE,
    S_COUNTING
  } state_t;

  state_t      r_state;
  logic [15:0] r_load;
  logic [15:0] r_count;
  logic [15:0] r_pcnt;
  logic        r_auto;
  logic        r_done;
  logic        r_irq;
  logic [15:0] r_rdata;

  logic        w_sel;
  logic        w_wr_load;
  logic        w_wr_ctrl;
  logic        w_wr_stat;
  logic        w_run;
  logic        w_tick;
  logic [15:0] w_rmux;
  logic        w_unused;

  assign w_sel     = (ADDR[15:12] == BASE);
  assign w_wr_load = W && w_sel && (ADDR[1:0] == 2'd0);
  assign w_wr_ctrl = W && w_sel && (ADDR[1:0] == 2'd2);
  assign w_wr_stat = W && w_sel && (ADDR[1:0] == 2'd3);
  assign w_run     = (r_state == S_COUNTING);
  assign w_tick    = w_run && (r_pcnt == P_MAX);
  assign w_unused  = ^ADDR[11:2];

  always_comb begin
    w_rmux = 16'd0;
    case (ADDR[1:0])
      2'd0:    w_rmux = r_load;
      2'd1:    w_rmux = r_count;
      2'd2:    w_rmux = {14'd0, r_auto, w_run};
      default: w_rmux = {15'd0, r_done};
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_load  <= 16'd0;
      r_count <= 16'd0;
      r_pcnt  <= 16'd0;
      r_auto  <= 1'b0;
      r_done  <= 1'b0;
      r_irq   <= 1'b0;
      r_rdata <= 16'd0;
    end else begin
      r_irq   <= 1'b0;
      r_rdata <= w_sel ? w_rmux : 16'd0;

      if (w_wr_load) r_load <= DOUT;
      // Clear is written before any expiry set below, so a colliding set wins.
      if (w_wr_stat) r_done <= 1'b0;

      if (w_wr_ctrl) begin
        // A CTRL write swallows any tick in the same cycle.
        r_auto <= DOUT[1];
        r_pcnt <= 16'd0;
        if (DOUT[0]) begin
          r_state <= S_COUNTING;
          r_count <= r_load;
        end else begin
          r_state <= S_IDLE;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_pcnt <= 16'd0;
          end
          S_COUNTING: begin
            if (w_tick) begin
              r_pcnt <= 16'd0;
              if (r_count > 16'd1) begin
                r_count <= r_count - 16'd1;
              end else begin
                r_done <= 1'b1;
                r_irq  <= 1'b1;
                if (r_auto) begin
                  r_count <= r_load;
                end else begin
                  r_count <= 16'd0;
                  r_state <= S_IDLE;
                end
              end
            end else begin
              r_pcnt <= r_pcnt + 16'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign rdata = r_rdata;
  assign irq   = r_irq;

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer with PRESCALE=4; inputs change 1 time unit after each rising edge.
module tb_bus_timer;

  logic        Clock;
  logic        Resetn;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] rdata;
  logic        irq;

  int n_total = 0;
  int n_pass  = 0;

  bus_timer #(.BASE(4'h4), .PRESCALE(4)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .ADDR  (ADDR),
    .DOUT  (DOUT),
    .W     (W),
    .rdata (rdata),
    .irq   (irq)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one bus cycle and return 1 unit after the edge that samples it.
  task automatic cyc(input logic [15:0] a, input logic [15:0] d, input logic w);
    ADDR = a;
    DOUT = d;
    W    = w;
    @(posedge Clock);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] v);
    cyc(a, 16'd0, 1'b0);
    v = rdata;
  endtask

  initial begin
    logic [15:0] v;
    Resetn = 1'b0;
    ADDR = 16'd0;
    DOUT = 16'd0;
    W = 1'b0;
    #23 Resetn = 1'b1;
    @(posedge Clock);
    #1;

    chk("rst_irq", {15'd0, irq}, 16'd0);
    chk("rst_rdata", rdata, 16'd0);
    rd(16'h4000, v); chk("rst_load", v, 16'd0);
    rd(16'h4001, v); chk("rst_count", v, 16'd0);
    rd(16'h4002, v); chk("rst_ctrl", v, 16'd0);
    rd(16'h4003, v); chk("rst_status", v, 16'd0);

    // One-shot LOAD=3: expiry at edge 12 after the RUN write.
    cyc(16'h4000, 16'd3, 1'b1);
    cyc(16'h4002, 16'h0001, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      cyc(16'h4001, 16'd0, 1'b0);
      if (k == 2)  chk("os_count3", rdata, 16'd3);
      if (k == 6)  chk("os_count2", rdata, 16'd2);
      if (k == 10) chk("os_count1", rdata, 16'd1);
      if (k >= 11) chk($sformatf("os_irq_e%0d", k), {15'd0, irq}, (k == 12) ? 16'd1 : 16'd0);
      if (k == 13) chk("os_count0", rdata, 16'd0);
    end
    rd(16'h4002, v); chk("os_ctrl", v, 16'h0000);
    rd(16'h4003, v); chk("os_done", v, 16'd1);

    cyc(16'h4003, 16'd0, 1'b1);
    rd(16'h4003, v); chk("clr_done", v, 16'd0);

    // Same one-shot with a STATUS write landing on the expiry edge.
    cyc(16'h4002, 16'h0001, 1'b1);
    repeat (11) cyc(16'h0000, 16'd0, 1'b0);
    cyc(16'h4003, 16'd0, 1'b1);
    chk("col_irq", {15'd0, irq}, 16'd1);
    rd(16'h4003, v); chk("col_done_set", v, 16'd1);
    cyc(16'h4003, 16'd0, 1'b1);
    rd(16'h4003, v); chk("col_done_clr", v, 16'd0);

    // Auto-reload LOAD=2: pulses at edges 8, 16, 24.
    cyc(16'h4000, 16'd2, 1'b1);
    cyc(16'h4002, 16'h0003, 1'b1);
    for (int k = 1; k <= 25; k++) begin
      cyc(16'h4001, 16'd0, 1'b0);
      chk($sformatf("ar_irq_e%0d", k), {15'd0, irq}, (k % 8 == 0) ? 16'd1 : 16'd0);
      if (k % 8 == 1 && k > 1) chk($sformatf("ar_reload_e%0d", k), rdata, 16'd2);
    end
    rd(16'h4002, v); chk("ar_ctrl", v, 16'h0003);
    rd(16'h4003, v); chk("ar_done_sticky", v, 16'd1);
    cyc(16'h4002, 16'h0000, 1'b1);
    cyc(16'h4003, 16'd0, 1'b1);
    rd(16'h4003, v); chk("ar_done_clr", v, 16'd0);

    // Stop after 10 ticks, then restart.
    cyc(16'h4000, 16'h00FF, 1'b1);
    cyc(16'h4002, 16'h0001, 1'b1);
    repeat (40) cyc(16'h0000, 16'd0, 1'b0);
    cyc(16'h4002, 16'h0000, 1'b1);
    repeat (6) cyc(16'h0000, 16'd0, 1'b0);
    rd(16'h4001, v); chk("stop_count", v, 16'h00F5);
    rd(16'h4002, v); chk("stop_ctrl", v, 16'h0000);
    cyc(16'h4002, 16'h0001, 1'b1);
    rd(16'h4001, v); chk("restart_count", v, 16'h00FF);
    cyc(16'h4002, 16'h0000, 1'b1);

    // Writes outside the selected window must be ignored.
    cyc(16'h1000, 16'h1234, 1'b1);
    cyc(16'h3002, 16'h0003, 1'b1);
    cyc(16'h3003, 16'h0000, 1'b1);
    rd(16'h1000, v); chk("dec_rdata0", v, 16'd0);
    rd(16'h4000, v); chk("dec_load", v, 16'h00FF);
    rd(16'h4002, v); chk("dec_ctrl", v, 16'h0000);

    // LOAD=0 expires on the first tick.
    cyc(16'h4000, 16'd0, 1'b1);
    cyc(16'h4002, 16'h0001, 1'b1);
    repeat (3) cyc(16'h0000, 16'd0, 1'b0);
    chk("l0_irq_e3", {15'd0, irq}, 16'd0);
    cyc(16'h0000, 16'd0, 1'b0);
    chk("l0_irq_e4", {15'd0, irq}, 16'd1);
    rd(16'h4003, v); chk("l0_done", v, 16'd1);

    // Asynchronous reset in the middle of a count.
    cyc(16'h4000, 16'd5, 1'b1);
    cyc(16'h4002, 16'h0001, 1'b1);
    for (int k = 1; k <= 7; k++) cyc(16'h4000, 16'd0, 1'b0);
    chk("mid_rdata_pre", rdata, 16'd5);
    #2 Resetn = 1'b0;
    #1;
    chk("mid_rdata_rst", rdata, 16'd0);
    chk("mid_irq_rst", {15'd0, irq}, 16'd0);
    #10 Resetn = 1'b1;
    @(posedge Clock);
    #1;
    for (int k = 1; k <= 10; k++) begin
      cyc(16'h4001, 16'd0, 1'b0);
      chk($sformatf("mid_irq_%0d", k), {15'd0, irq}, 16'd0);
    end
    chk("mid_count", rdata, 16'd0);
    rd(16'h4000, v); chk("mid_load", v, 16'd0);
    rd(16'h4002, v); chk("mid_ctrl", v, 16'd0);
    rd(16'h4003, v); chk("mid_status", v, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
